// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the regfile writeback path.
// Requester indices fix the priority-ring order of the write port.
package regfile_ctrl_pkg;

    localparam int NREQ_DEF = 3;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr_i upward (mod N) for the first valid.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: round-robin among writeback sources,
// registered write stage, and a RAW pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][4:0]        req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        wen,
    output logic [4:0]                  write_addr,
    output logic [DATA_W-1:0]           write_data,
    input  logic                        set_busy,
    input  logic [4:0]                  set_addr,
    output logic [31:0]                 busy_mask
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              wen_q, wen_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0]       busy_q, busy_d;

    logic [NREQ-1:0]   valid_eff;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;

    // Nothing is consumed while reset is held.
    assign valid_eff = req_valid & {NREQ{reset}};

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .valid_i (valid_eff),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (gnt_any) begin
            waddr_d  = req_addr[gnt_idx];
            wdata_d  = req_data[gnt_idx];
            wen_d    = (req_addr[gnt_idx] != REG_ZERO);
            rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Set after clear so a new producer wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) busy_d[waddr_q] = 1'b0;
        if (set_busy && set_addr != REG_ZERO) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready  = gnt;
    assign wen        = wen_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;
    assign busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus
// scoreboard / reset corner sequences.
module tb_regfile_wb_arbiter;

    logic             clk;
    logic             rst_n;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_addr;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic             wen;
    logic [4:0]       write_addr;
    logic [31:0]      write_data;
    logic             set_busy;
    logic [4:0]       set_addr;
    logic [31:0]      busy_mask;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.NREQ(3), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wen        (wen),
        .write_addr (write_addr),
        .write_data (write_data),
        .set_busy   (set_busy),
        .set_addr   (set_addr),
        .busy_mask  (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       v;
        logic [2:0][4:0]  a;
        logic [2:0][31:0] d;
        logic [2:0]       rdy;
        logic             wen;
        logic [4:0]       wa;
        logic [31:0]      wd;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        logic [2:0] v,
        logic [4:0] a2, logic [4:0] a1, logic [4:0] a0,
        logic [31:0] d2, logic [31:0] d1, logic [31:0] d0,
        logic [2:0] rdy, logic w, logic [4:0] wa, logic [31:0] wd);
        vec_t r;
        r.v   = v;
        r.a   = {a2, a1, a0};
        r.d   = {d2, d1, d0};
        r.rdy = rdy;
        r.wen = w;
        r.wa  = wa;
        r.wd  = wd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        set_busy  = 1'b0;
        set_addr  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, a};
        req_data  = {32'd0, 32'd0, d};
    endtask

    initial begin
        // ptr starts 0; sequence exercises every rotation and the $zero drop
        vecs[0]  = mk(3'b001, 0, 0, 5, 0, 0, 32'hDEADBEEF,
                      3'b001, 1, 5, 32'hDEADBEEF);
        vecs[1]  = mk(3'b100, 4, 0, 0, 32'h44, 0, 0,
                      3'b100, 1, 4, 32'h44);
        vecs[2]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b001, 1, 1, 32'h11);
        vecs[3]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b010, 1, 2, 32'h22);
        vecs[4]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b100, 1, 3, 32'h33);
        vecs[5]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b001, 1, 1, 32'h11);
        vecs[6]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b010, 1, 2, 32'h22);
        vecs[7]  = mk(3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11,
                      3'b100, 1, 3, 32'h33);
        vecs[8]  = mk(3'b010, 0, 0, 0, 0, 32'h1234, 0,
                      3'b010, 0, 0, 32'h1234);
        vecs[9]  = mk(3'b011, 0, 2, 6, 0, 32'h22, 32'h66,
                      3'b001, 1, 6, 32'h66);
        vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 0,
                      3'b000, 0, 6, 32'h66);
        vecs[11] = mk(3'b101, 8, 0, 1, 32'h88, 0, 32'h11,
                      3'b100, 1, 8, 32'h88);

        rst_n = 1'b0;
        idle_inputs();
        req_valid = 3'b111;
        #2;
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_waddr", 64'(write_addr), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        chk("rst_hold_wen", 64'(wen), 64'd0);
        idle_inputs();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            req_valid = vecs[i].v;
            req_addr  = vecs[i].a;
            req_data  = vecs[i].d;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].rdy));
            tick();
            chk($sformatf("v%0d_wen", i), 64'(wen), 64'(vecs[i].wen));
            chk($sformatf("v%0d_waddr", i), 64'(write_addr), 64'(vecs[i].wa));
            chk($sformatf("v%0d_wdata", i), 64'(write_data), 64'(vecs[i].wd));
            chk($sformatf("v%0d_busy", i), 64'(busy_mask), 64'd0);
        end
        idle_inputs();

        // Mark r7 pending, then retire it through the ALU.
        set_busy = 1'b1;
        set_addr = 5'd7;
        tick();
        idle_inputs();
        chk("set7_busy", 64'(busy_mask), 64'h80);
        tick();
        chk("set7_hold", 64'(busy_mask), 64'h80);
        drive_alu(5'd7, 32'h7777);
        #1;
        chk("w7_ready", 64'(req_ready), 64'b001);
        tick();
        idle_inputs();
        chk("w7_n1_wen", 64'(wen), 64'd1);
        chk("w7_n1_busy", 64'(busy_mask), 64'h80);
        tick();
        chk("w7_n2_busy", 64'(busy_mask), 64'h0);
        chk("w7_n2_wen", 64'(wen), 64'd0);

        // A set on r0 is ignored.
        set_busy = 1'b1;
        set_addr = 5'd0;
        tick();
        idle_inputs();
        chk("set0_ignored", 64'(busy_mask), 64'h0);

        // Set and clear of r9 on the same edge: set wins.
        set_busy = 1'b1;
        set_addr = 5'd9;
        tick();
        idle_inputs();
        drive_alu(5'd9, 32'h9999);
        tick();
        idle_inputs();
        chk("w9_wen", 64'(wen), 64'd1);
        chk("w9_waddr", 64'(write_addr), 64'd9);
        set_busy = 1'b1;
        set_addr = 5'd9;
        tick();
        idle_inputs();
        chk("w9_setwins", 64'(busy_mask), 64'h200);
        tick();
        tick();
        chk("w9_held", 64'(busy_mask), 64'h200);

        // Build 0x0F00, put a write in flight, then reset mid-operation.
        set_busy = 1'b1;
        set_addr = 5'd8;
        tick();
        set_addr = 5'd10;
        tick();
        set_addr = 5'd11;
        tick();
        idle_inputs();
        drive_alu(5'd12, 32'hC0C0);
        tick();
        idle_inputs();
        chk("pre_rst_wen", 64'(wen), 64'd1);
        chk("pre_rst_busy", 64'(busy_mask), 64'h0F00);
        #2;
        rst_n = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33, 32'h22, 32'h11};
        #1;
        chk("mid_rst_wen", 64'(wen), 64'd0);
        chk("mid_rst_busy", 64'(busy_mask), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("mid_rst_nowrite", 64'(wen), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b001);
        tick();
        chk("post_rst_waddr", 64'(write_addr), 64'd1);
        chk("post_rst_wen", 64'(wen), 64'd1);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
